axi_s_s_pkt: RTL

AXI_S_S_PKT -- requirements
Module: axi_s_s_pkt

---
 rtl/axi_s_s_pkt.sv | 107 ++++++++++
 1 files changed

// File: rtl/axi_s_s_pkt.sv
// AXI-Stream byte sink: beats go into a DEPTH-entry FIFO drained by rd_en,
// while a two-state packet tracker reports per-packet length, byte sum and overlength.
module axi_s_s_pkt #(
    parameter int DEPTH  = 8,
    parameter int MAXLEN = 15
) (
    input  logic        s_aclk,
    input  logic        s_resetn,
    input  logic        s_tvalid,
    input  logic [7:0]  s_tdata,
    input  logic        s_tlast,
    output logic        s_tready,
    input  logic        rd_en,
    output logic [7:0]  dout,
    output logic        dout_valid,
    output logic        empty,
    output logic        full,
    output logic        pkt_done,
    output logic [3:0]  pkt_len,
    output logic [11:0] pkt_sum,
    output logic        pkt_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        wr_fire, rd_fire;
    logic [0:0]  state;
    logic [3:0]  len_acc;
    logic [11:0] sum_acc;
    logic [4:0]  cnt_nxt;
    logic [11:0] sum_nxt;

    function automatic logic [3:0] sat_len(input logic [4:0] c);
        return c[4] ? 4'hF : c[3:0];
    endfunction

    // The wrap bit distinguishes full from empty when the index bits match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign s_tready = s_resetn && !full;
    assign wr_fire  = s_tvalid && s_tready;
    assign rd_fire  = rd_en && !empty;

    always_ff @(posedge s_aclk) begin
        if (wr_fire) mem[wr_ptr[AW-1:0]] <= s_tdata;
    end

    always_ff @(posedge s_aclk or negedge s_resetn) begin
        if (!s_resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= rd_fire;
            if (wr_fire) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                dout   <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    // Running totals including the beat being accepted this cycle.
    always_comb begin
        cnt_nxt = 5'd1;
        sum_nxt = {4'b0, s_tdata};
        if (state == RECV) begin
            cnt_nxt = {1'b0, len_acc} + 5'd1;
            sum_nxt = sum_acc + {4'b0, s_tdata};
        end
    end

    always_ff @(posedge s_aclk or negedge s_resetn) begin
        if (!s_resetn) begin
            state    <= IDLE;
            len_acc  <= '0;
            sum_acc  <= '0;
            pkt_done <= 1'b0;
            pkt_len  <= '0;
            pkt_sum  <= '0;
            pkt_err  <= 1'b0;
        end else begin
            pkt_done <= wr_fire && s_tlast;
            if (wr_fire) begin
                if (s_tlast) begin
                    state   <= IDLE;
                    len_acc <= '0;
                    sum_acc <= '0;
                    pkt_len <= sat_len(cnt_nxt);
                    pkt_sum <= sum_nxt;
                    pkt_err <= (cnt_nxt > 5'(MAXLEN));
                end else begin
                    state   <= RECV;
                    len_acc <= sat_len(cnt_nxt);
                    sum_acc <= sum_nxt;
                end
            end
        end
    end

endmodule
